// File: rtl/datapath_pkg.sv
// datapath_pkg
//   Shared constants for the single-bus datapath:
//   - ALU opcode encodings (5-bit, selected by IRout)
//   - bus-source indices, where a lower index means higher bus priority
//   - sign-extension helper for the C (immediate) bus source
package datapath_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_NEG  = 5'b01110;
  localparam logic [4:0] OP_NOT  = 5'b01111;

  // Bus source indices. Index 0 wins when several selects are high.
  localparam int SEL_R0     = 0;   // R0..R15 occupy 0..15
  localparam int SEL_HI     = 16;
  localparam int SEL_LO     = 17;
  localparam int SEL_ZHI    = 18;
  localparam int SEL_ZLO    = 19;
  localparam int SEL_PC     = 20;
  localparam int SEL_MDR    = 21;
  localparam int SEL_INPORT = 22;
  localparam int SEL_C      = 23;
  localparam int NUM_SEL    = 24;

  function automatic logic [31:0] sext19(input logic [18:0] v);
    return {{13{v[18]}}, v};
  endfunction

endpackage

// File: rtl/datapath_if.sv
// datapath_if
//   Control and memory-side signals of the datapath, bundled as one interface.
//   master: control unit / bench (drives strobes, memory data; observes mar, ir)
//   slave : datapath (consumes strobes; drives mar, ir)
//   Signals:
//     Read, Mdatain          MDR source select and memory read data
//     IRout                  ALU opcode select
//     PCin..LOin, Rin[7:0]   register load enables
//     IncPC                  forces the ALU to Bus+1
//     PCout..Cout, Rout[15:0] bus-driver selects
//     mar, ir                current MAR / IR contents
interface datapath_if;
  logic        Read;
  logic [31:0] Mdatain;
  logic [4:0]  IRout;
  logic        PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin;
  logic [7:0]  Rin;
  logic        IncPC;
  logic        PCout, MDRout, HIout, LOout, Zhiout, Zlowout, InPortout, Cout;
  logic [15:0] Rout;
  logic [31:0] mar;
  logic [31:0] ir;

  modport master (
    output Read, Mdatain, IRout,
    output PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, Rin,
    output IncPC,
    output PCout, MDRout, HIout, LOout, Zhiout, Zlowout, InPortout, Cout, Rout,
    input  mar, ir
  );

  modport slave (
    input  Read, Mdatain, IRout,
    input  PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, Rin,
    input  IncPC,
    input  PCout, MDRout, HIout, LOout, Zhiout, Zlowout, InPortout, Cout, Rout,
    output mar, ir
  );
endinterface

// File: rtl/datapath_alu.sv
// datapath_alu
//   Combinational ALU. A comes from Y, B from the bus; shift/rotate
//   amount is B[4:0]. Result is {hi, lo}; single-word ops leave hi = 0.
//   Ports:
//     a, b    in  32  operands
//     op      in  5   opcode (datapath_pkg OP_*)
//     incpc   in  1   overrides op with lo = b + 1
//     result  out 64  {hi, lo}
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  input  logic        incpc,
  output logic [63:0] result
);

  logic [4:0]  sh;
  logic [63:0] ror_w;
  logic [63:0] rol_w;
  logic [63:0] prod;

  assign sh = b[4:0];
  // Rotations shift a doubled copy of A so the wrapped bits fall into place.
  assign ror_w = {a, a} >> sh;
  assign rol_w = {a, a} << sh;
  assign prod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  always_comb begin
    result = '0;
    if (incpc) begin
      result = {32'd0, b + 32'd1};
    end else begin
      case (op)
        OP_ADD:  result = {32'd0, a + b};
        OP_SUB:  result = {32'd0, a - b};
        OP_SHR:  result = {32'd0, a >> sh};
        OP_SHRA: result = {32'd0, $signed(a) >>> sh};
        OP_SHL:  result = {32'd0, a << sh};
        OP_ROR:  result = {32'd0, ror_w[31:0]};
        OP_ROL:  result = {32'd0, rol_w[63:32]};
        OP_AND:  result = {32'd0, a & b};
        OP_OR:   result = {32'd0, a | b};
        OP_MUL:  result = prod;
        OP_DIV: begin
          if (b == 32'd0) begin
            result = {a, 32'hFFFF_FFFF};
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            // Most-negative / -1 overflows; the wrapped quotient is A itself.
            result = {32'd0, a};
          end else begin
            result = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
          end
        end
        OP_NEG:  result = {32'd0, 32'd0 - b};
        OP_NOT:  result = {32'd0, ~b};
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// datapath
//   32-bit single-bus CPU datapath: R0-R15, PC, IR, HI, LO, Y, 64-bit Z,
//   MAR, MDR, InPort and the ALU. The *out selects pick one bus driver
//   (fixed priority), *in enables load registers from the bus on clk.
//   Ports:
//     clk     in   1   clock, rising edge
//     Clear   in   1   synchronous active-high reset, zeroes every register
//     ctl     slave    control strobes, memory data, mar/ir observation
//     Busout  out  32  current bus value (combinational)
//     R0_out  out  32  R0 contents
module datapath
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        Clear,
  datapath_if.slave   ctl,
  output logic [31:0] Busout,
  output logic [31:0] R0_out
);

  logic [31:0] r_q [8];     // R8-R15 have no load path and read as 0
  logic [31:0] pc_q, ir_q, hi_q, lo_q, y_q, mar_q, mdr_q, in_port_q;
  logic [63:0] z_q;

  logic [NUM_SEL-1:0] sel;
  logic [31:0]        src [NUM_SEL];
  logic [31:0]        bus;
  logic [63:0]        alu_result;

  assign sel = {ctl.Cout, ctl.InPortout, ctl.MDRout, ctl.PCout,
                ctl.Zlowout, ctl.Zhiout, ctl.LOout, ctl.HIout, ctl.Rout};

  always_comb begin
    for (int i = 0; i < 8; i++)  src[SEL_R0 + i] = r_q[i];
    for (int i = 8; i < 16; i++) src[SEL_R0 + i] = '0;
    src[SEL_HI]     = hi_q;
    src[SEL_LO]     = lo_q;
    src[SEL_ZHI]    = z_q[63:32];
    src[SEL_ZLO]    = z_q[31:0];
    src[SEL_PC]     = pc_q;
    src[SEL_MDR]    = mdr_q;
    src[SEL_INPORT] = in_port_q;
    src[SEL_C]      = sext19(ir_q[18:0]);
  end

  // Scan from lowest to highest priority so the lowest active index wins.
  always_comb begin
    bus = '0;
    for (int i = NUM_SEL - 1; i >= 0; i--) begin
      if (sel[i]) bus = src[i];
    end
  end

  datapath_alu u_alu (
    .a      (y_q),
    .b      (bus),
    .op     (ctl.IRout),
    .incpc  (ctl.IncPC),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (Clear) begin
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= '0;
      z_q       <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      in_port_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (ctl.Rin[i]) r_q[i] <= bus;
      end
      if (ctl.PCin)  pc_q  <= bus;
      if (ctl.IRin)  ir_q  <= bus;
      if (ctl.HIin)  hi_q  <= bus;
      if (ctl.LOin)  lo_q  <= bus;
      if (ctl.Yin)   y_q   <= bus;
      if (ctl.Zin)   z_q   <= alu_result;
      if (ctl.MARin) mar_q <= bus;
      if (ctl.MDRin) mdr_q <= ctl.Read ? ctl.Mdatain : bus;
      // No external input port in this version; the register stays at 0.
      in_port_q <= '0;
    end
  end

  assign Busout  = bus;
  assign R0_out  = r_q[0];
  assign ctl.mar = mar_q;
  assign ctl.ir  = ir_q;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic        clk = 1'b0;
  logic        Clear;
  logic [31:0] Busout;
  logic [31:0] R0_out;

  datapath_if ctl ();

  datapath dut (
    .clk    (clk),
    .Clear  (Clear),
    .ctl    (ctl),
    .Busout (Busout),
    .R0_out (R0_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_hi, m_lo, m_y, m_mar, m_mdr;
  logic [63:0] m_z;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = '0; m_ir = '0; m_hi = '0; m_lo = '0; m_y = '0;
    m_mar = '0; m_mdr = '0; m_z = '0;
  endtask

  task automatic idle();
    Clear = 1'b0;
    ctl.Read = 1'b0; ctl.Mdatain = '0; ctl.IRout = '0; ctl.IncPC = 1'b0;
    ctl.PCin = 1'b0; ctl.IRin = 1'b0; ctl.Yin = 1'b0; ctl.Zin = 1'b0;
    ctl.MARin = 1'b0; ctl.MDRin = 1'b0; ctl.HIin = 1'b0; ctl.LOin = 1'b0;
    ctl.Rin = '0; ctl.Rout = '0;
    ctl.PCout = 1'b0; ctl.MDRout = 1'b0; ctl.HIout = 1'b0; ctl.LOout = 1'b0;
    ctl.Zhiout = 1'b0; ctl.Zlowout = 1'b0; ctl.InPortout = 1'b0; ctl.Cout = 1'b0;
  endtask

  // Source numbering follows the bus priority list: R0..R15, HI, LO, Zhi, Zlo, PC, MDR, InPort, C
  task automatic set_sel(input int idx);
    if (idx < 16) ctl.Rout[idx] = 1'b1;
    else case (idx)
      16: ctl.HIout = 1'b1;
      17: ctl.LOout = 1'b1;
      18: ctl.Zhiout = 1'b1;
      19: ctl.Zlowout = 1'b1;
      20: ctl.PCout = 1'b1;
      21: ctl.MDRout = 1'b1;
      22: ctl.InPortout = 1'b1;
      default: ctl.Cout = 1'b1;
    endcase
  endtask

  function automatic logic [31:0] ref_bus();
    int cval;
    for (int i = 0; i < 16; i++) if (ctl.Rout[i]) return m_r[i];
    if (ctl.HIout) return m_hi;
    if (ctl.LOout) return m_lo;
    if (ctl.Zhiout) return m_z[63:32];
    if (ctl.Zlowout) return m_z[31:0];
    if (ctl.PCout) return m_pc;
    if (ctl.MDRout) return m_mdr;
    if (ctl.InPortout) return 32'd0;
    if (ctl.Cout) begin
      cval = int'(m_ir[18:0]);
      if (m_ir[18]) cval = cval - 524288;
      return 32'(cval);
    end
    return 32'd0;
  endfunction

  function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op, input logic inc);
    longint sa, sb, q, r, t64;
    int sh;
    logic [31:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    t  = a;
    if (inc) return {32'd0, b + 32'd1};
    case (op)
      5'd3:  return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5:  return {32'd0, a >> sh};
      5'd6: begin t64 = sa >>> sh; return {32'd0, t64[31:0]}; end
      5'd7:  return {32'd0, a << sh};
      5'd8: begin for (int k = 0; k < sh; k++) t = {t[0], t[31:1]}; return {32'd0, t}; end
      5'd9: begin for (int k = 0; k < sh; k++) t = {t[30:0], t[31]}; return {32'd0, t}; end
      5'd10: return {32'd0, a & b};
      5'd11: return {32'd0, a | b};
      5'd12: begin t64 = sa * sb; return t64; end
      5'd13: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      5'd14: return {32'd0, 32'd0 - b};
      5'd15: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  // One micro-step: check the bus, clock, update the model, check registered views.
  task automatic step(input string tag);
    logic [31:0] eb;
    logic [63:0] nz;
    logic [31:0] nmdr;
    #1;
    eb = ref_bus();
    chk({tag, "_bus"}, 64'(Busout), 64'(eb));
    nz   = ref_alu(m_y, eb, ctl.IRout, ctl.IncPC);
    nmdr = ctl.Read ? ctl.Mdatain : eb;
    @(posedge clk);
    if (Clear) model_reset();
    else begin
      for (int i = 0; i < 8; i++) if (ctl.Rin[i]) m_r[i] = eb;
      if (ctl.PCin)  m_pc  = eb;
      if (ctl.IRin)  m_ir  = eb;
      if (ctl.HIin)  m_hi  = eb;
      if (ctl.LOin)  m_lo  = eb;
      if (ctl.Yin)   m_y   = eb;
      if (ctl.Zin)   m_z   = nz;
      if (ctl.MARin) m_mar = eb;
      if (ctl.MDRin) m_mdr = nmdr;
    end
    #1;
    chk({tag, "_r0"}, 64'(R0_out), 64'(m_r[0]));
    chk({tag, "_mar"}, 64'(ctl.mar), 64'(m_mar));
    chk({tag, "_ir"}, 64'(ctl.ir), 64'(m_ir));
    idle();
  endtask

  task automatic mem_to(input logic [31:0] val, input int dest);
    ctl.Read = 1'b1; ctl.Mdatain = val; ctl.MDRin = 1'b1; step("mem_mdr");
    ctl.MDRout = 1'b1;
    if (dest < 8) ctl.Rin[dest] = 1'b1; else ctl.Yin = 1'b1;
    step("mdr_dest");
  endtask

  task automatic peek(input string tag, input int idx, input logic [31:0] exp);
    set_sel(idx);
    #1;
    chk(tag, 64'(Busout), 64'(exp));
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    Clear = 1'b1;
    @(posedge clk); #1;
    Clear = 1'b0;
    chk("rst_bus", 64'(Busout), 64'd0);
    chk("rst_r0", 64'(R0_out), 64'd0);
    for (int i = 0; i < 24; i++) peek("rst_scan", i, 32'd0);

    // Memory -> MDR -> R1
    mem_to(32'd1, 1);
    peek("r1_eq_1", 1, 32'd1);

    // Y = 30, SHR by R1 = 1
    mem_to(32'd30, 8);
    ctl.Rout[1] = 1'b1; ctl.IRout = 5'b00101; ctl.Zin = 1'b1; step("shr");
    peek("shr_zlo", 19, 32'd15);

    // Y = 7, R2 = 3: MUL, DIV, DIV by zero (R8 reads 0)
    mem_to(32'd7, 8);
    mem_to(32'd3, 2);
    ctl.Rout[2] = 1'b1; ctl.IRout = 5'b01100; ctl.Zin = 1'b1; step("mul");
    peek("mul_zhi", 18, 32'd0);
    peek("mul_zlo", 19, 32'd21);
    ctl.Rout[2] = 1'b1; ctl.IRout = 5'b01101; ctl.Zin = 1'b1; step("div");
    peek("div_zlo", 19, 32'd2);
    peek("div_zhi", 18, 32'd1);
    ctl.Rout[8] = 1'b1; ctl.IRout = 5'b01101; ctl.Zin = 1'b1; step("div0");
    peek("div0_zlo", 19, 32'hFFFF_FFFF);
    peek("div0_zhi", 18, 32'd7);

    // PC increment twice through Z
    for (int n = 1; n <= 2; n++) begin
      ctl.PCout = 1'b1; ctl.IncPC = 1'b1; ctl.Zin = 1'b1; step("pc_inc");
      ctl.Zlowout = 1'b1; ctl.PCin = 1'b1; step("pc_ld");
      peek("pc_val", 20, 32'(n));
    end

    // Priority R0 over MDR, then empty bus
    mem_to(32'hABCD_0123, 0);
    ctl.Read = 1'b1; ctl.Mdatain = 32'd55; ctl.MDRin = 1'b1; step("mdr55");
    ctl.Rout[0] = 1'b1; ctl.MDRout = 1'b1;
    #1;
    chk("prio_r0", 64'(Busout), 64'h0000_0000_ABCD_0123);
    idle();
    #1;
    chk("empty_bus", 64'(Busout), 64'd0);

    // Random micro-steps against the reference model
    for (int n = 0; n < 400; n++) begin
      int k;
      k = int'($urandom_range(0, 25));
      if (k < 24) set_sel(k);
      else if (k == 24) begin
        set_sel(int'($urandom_range(0, 23)));
        set_sel(int'($urandom_range(0, 23)));
      end
      ctl.IRout   = 5'($urandom_range(0, 17));
      ctl.IncPC   = ($urandom_range(0, 7) == 0);
      ctl.Read    = 1'($urandom);
      ctl.Mdatain = $urandom;
      ctl.Rin     = 8'($urandom) & 8'($urandom);
      ctl.PCin    = ($urandom_range(0, 3) == 0);
      ctl.IRin    = ($urandom_range(0, 3) == 0);
      ctl.Yin     = ($urandom_range(0, 3) == 0);
      ctl.Zin     = ($urandom_range(0, 1) == 0);
      ctl.MARin   = ($urandom_range(0, 3) == 0);
      ctl.MDRin   = ($urandom_range(0, 2) == 0);
      ctl.HIin    = ($urandom_range(0, 3) == 0);
      ctl.LOin    = ($urandom_range(0, 3) == 0);
      Clear       = ($urandom_range(0, 49) == 0);
      step("rnd");
    end

    // Clear from arbitrary state, with load enables active
    mem_to(32'h1234_5678, 0);
    Clear = 1'b1; ctl.Rin = 8'hFF; ctl.MDRout = 1'b1; ctl.Yin = 1'b1; ctl.Zin = 1'b1;
    step("clear");
    chk("clr_r0", 64'(R0_out), 64'd0);
    for (int i = 0; i < 24; i++) peek("clr_scan", i, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
